// File: rtl/cfs_aligner.sv
// Byte-stream realigner: packs 1..4-byte MD RX transfers into an 8-byte buffer and
// emits fixed-size/offset MD TX transfers programmed over APB.
module cfs_aligner #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] paddr,
  input  logic          pwrite,
  input  logic          psel,
  input  logic          penable,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  input  logic          md_rx_valid,
  input  logic [DW-1:0] md_rx_data,
  input  logic [1:0]    md_rx_offset,
  input  logic [2:0]    md_rx_size,
  output logic          md_rx_ready,
  output logic          md_rx_err,
  output logic          md_tx_valid,
  output logic [DW-1:0] md_tx_data,
  output logic [1:0]    md_tx_offset,
  output logic [2:0]    md_tx_size,
  input  logic          md_tx_ready,
  input  logic          md_tx_err
);
  // rst_n is active-high despite its name.
  wire rst = rst_n;

  logic [7:0]    buf_q [8];
  logic [7:0]    buf_d [8];
  logic [3:0]    lvl_q, lvl_d;
  logic [2:0]    ctrl_size_q;
  logic [1:0]    ctrl_off_q;
  logic [7:0]    cnt_q;
  logic          tx_valid_q;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [1:0]    tx_off_q;
  logic [2:0]    tx_size_q;

  // RX acceptance: credit comes only from the registered level.
  logic       rx_legal, rx_space, push, drop, pop, tx_start;
  logic [3:0] push_n, pop_n;
  assign rx_legal = (md_rx_size != 3'd0) && (({2'b0, md_rx_offset} + {1'b0, md_rx_size}) <= 4'd4);
  assign rx_space = (4'd8 - lvl_q) >= {1'b0, md_rx_size};
  assign push     = md_rx_valid & rx_legal & rx_space;
  assign drop     = md_rx_valid & ~rx_legal;
  assign pop      = tx_valid_q & md_tx_ready;
  assign push_n   = push ? {1'b0, md_rx_size} : 4'd0;
  assign pop_n    = pop ? {1'b0, tx_size_q} : 4'd0;
  assign lvl_d    = lvl_q + push_n - pop_n;
  assign tx_start = ~tx_valid_q & (lvl_d >= {1'b0, ctrl_size_q});

  assign md_rx_ready = ~rst & md_rx_valid & (~rx_legal | rx_space);
  assign md_rx_err   = ~rst & drop;

  // Next buffer: shift out popped bytes, then append RX lanes behind the survivors.
  logic [4:0] src, k;
  logic [1:0] lane;
  always_comb begin
    src  = '0;
    k    = '0;
    lane = '0;
    for (int i = 0; i < 8; i++) begin
      src      = 5'(i) + {1'b0, pop_n};
      buf_d[i] = 8'h00;
      if (src < {1'b0, lvl_q}) begin
        buf_d[i] = buf_q[src[2:0]];
      end else begin
        k = src - {1'b0, lvl_q};
        if (k < {1'b0, push_n}) begin
          lane     = md_rx_offset + k[1:0];
          buf_d[i] = md_rx_data[{lane, 3'b000} +: 8];
        end
      end
    end
  end

  logic [2:0] rel;
  always_comb begin
    tx_data_d = '0;
    rel       = '0;
    for (int j = 0; j < 4; j++) begin
      rel = 3'(j) - {1'b0, ctrl_off_q};
      if (2'(j) >= ctrl_off_q && rel < ctrl_size_q) tx_data_d[8*j +: 8] = buf_d[rel];
    end
  end

  // APB decode
  logic acc, sel_ctrl, sel_stat, wbad, ctrl_wr, clr;
  assign acc      = psel & penable & ~rst;
  assign sel_ctrl = paddr == AW'(16'h0000);
  assign sel_stat = paddr == AW'(16'h000C);
  assign wbad     = (pwdata[2:0] == 3'd0) || (({2'b0, pwdata[9:8]} + {1'b0, pwdata[2:0]}) > 4'd4);
  assign ctrl_wr  = acc & pwrite & sel_ctrl & ~wbad;
  assign clr      = ctrl_wr & pwdata[16];

  assign pready  = acc;
  assign pslverr = acc & (~(sel_ctrl | sel_stat) | (pwrite & sel_stat) | (pwrite & sel_ctrl & wbad));
  always_comb begin
    prdata = '0;
    if (acc && !pwrite) begin
      if (sel_ctrl)      prdata = DW'({ctrl_off_q, 5'b0, ctrl_size_q});
      else if (sel_stat) prdata = DW'({lvl_q, cnt_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'h00;
      lvl_q       <= '0;
      ctrl_size_q <= 3'd1;
      ctrl_off_q  <= '0;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_off_q    <= '0;
      tx_size_q   <= '0;
    end else begin
      for (int i = 0; i < 8; i++) buf_q[i] <= buf_d[i];
      lvl_q <= lvl_d;
      if (pop) begin
        tx_valid_q <= 1'b0;
      end else if (tx_start) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= tx_data_d;
        tx_off_q   <= ctrl_off_q;
        tx_size_q  <= ctrl_size_q;
      end
      if (ctrl_wr) begin
        ctrl_size_q <= pwdata[2:0];
        ctrl_off_q  <= pwdata[9:8];
      end
      // A clear coinciding with a drop leaves exactly one count.
      if (clr)                        cnt_q <= {7'd0, drop};
      else if (drop && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign md_tx_valid  = tx_valid_q;
  assign md_tx_data   = tx_data_q;
  assign md_tx_offset = tx_off_q;
  assign md_tx_size   = tx_size_q;

  // Downstream TX errors do not alter completion.
  logic unused_ok;
  assign unused_ok = md_tx_err;
endmodule

// File: tb/tb_cfs_aligner.sv
// Bench for cfs_aligner: byte-queue reference model checked every cycle, plus directed literals.
module tb_cfs_aligner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] paddr = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] pwdata = '0, prdata;
  logic        pready, pslverr;
  logic        md_rx_valid = 1'b0;
  logic [31:0] md_rx_data = '0;
  logic [1:0]  md_rx_offset = '0;
  logic [2:0]  md_rx_size = '0;
  logic        md_rx_ready, md_rx_err;
  logic        md_tx_valid;
  logic [31:0] md_tx_data;
  logic [1:0]  md_tx_offset;
  logic [2:0]  md_tx_size;
  logic        md_tx_ready = 1'b0, md_tx_err = 1'b0;

  always #5 clk = ~clk;

  cfs_aligner #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data), .md_rx_offset(md_rx_offset),
    .md_rx_size(md_rx_size), .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
    .md_tx_valid(md_tx_valid), .md_tx_data(md_tx_data), .md_tx_offset(md_tx_offset),
    .md_tx_size(md_tx_size), .md_tx_ready(md_tx_ready), .md_tx_err(md_tx_err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte FIFO plus the in-flight TX transfer.
  logic [7:0]  q[$];
  logic [7:0]  txlog[$];
  int          m_size = 1, m_off = 0, m_cnt = 0, m_txo = 0, m_txs = 0;
  bit          m_txv = 0;
  logic [31:0] m_txd = '0;

  always @(negedge clk) begin : model
    int lvl, sz, of;
    bit legal, pushing, popping, drop, was_v, acc, bad, cwr;
    logic [31:0] sh;
    logic [31:0] exp_rd;
    if (rst_n) begin
      q.delete();
      m_size = 1; m_off = 0; m_cnt = 0; m_txv = 0; m_txd = '0;
    end else begin
      lvl     = q.size();
      sz      = int'(md_rx_size);
      of      = int'(md_rx_offset);
      legal   = (sz != 0) && (of + sz <= 4);
      pushing = md_rx_valid && legal && (8 - lvl >= sz);
      drop    = md_rx_valid && !legal;
      chk("rx_ready", md_rx_ready, md_rx_valid && (!legal || (8 - lvl >= sz)));
      chk("rx_err", md_rx_err, drop);
      chk("tx_valid", md_tx_valid, m_txv);
      if (m_txv) begin
        chk("tx_data", md_tx_data, m_txd);
        chk("tx_offset", md_tx_offset, m_txo);
        chk("tx_size", md_tx_size, m_txs);
      end
      acc = psel && penable;
      bad = (pwdata[2:0] == 0) || (int'(pwdata[9:8]) + int'(pwdata[2:0]) > 4);
      chk("pready", pready, acc);
      if (acc) begin
        chk("pslverr", pslverr, !(paddr == 16'h0 || paddr == 16'hC) ||
                                (pwrite && paddr == 16'hC) || (pwrite && paddr == 16'h0 && bad));
        if (!pwrite) begin
          exp_rd = 0;
          if (paddr == 16'h0) exp_rd = 32'(m_off * 256 + m_size);
          if (paddr == 16'hC) exp_rd = 32'(lvl * 256 + m_cnt);
          chk("prdata", prdata, exp_rd);
        end
      end
      cwr = acc && pwrite && paddr == 16'h0 && !bad;
      // advance to the state after the coming rising edge
      was_v   = m_txv;
      popping = m_txv && md_tx_ready;
      if (popping) begin
        txlog.push_back(m_txd[8*m_txo +: 8]);
        for (int i = 0; i < m_txs; i++) void'(q.pop_front());
        m_txv = 0;
      end
      if (pushing)
        for (int i = 0; i < sz; i++) begin
          sh = md_rx_data >> (8 * (of + i));
          q.push_back(sh[7:0]);
        end
      if (cwr && pwdata[16]) m_cnt = 0;
      if (drop && m_cnt < 255) m_cnt++;
      if (!was_v && q.size() >= m_size) begin
        m_txv = 1; m_txo = m_off; m_txs = m_size; m_txd = '0;
        for (int j = 0; j < m_size; j++) m_txd = m_txd | (32'(q[j]) << (8 * (m_off + j)));
      end
      if (cwr) begin
        m_size = int'(pwdata[2:0]);
        m_off  = int'(pwdata[9:8]);
      end
    end
  end

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output bit err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    #3 err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output bit err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    #3 begin d = prdata; err = pslverr; end
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic rx_push(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s, output bit err);
    bit ok = 0;
    @(posedge clk); #1;
    md_rx_valid = 1; md_rx_data = d; md_rx_offset = o; md_rx_size = s;
    for (int c = 0; c < 50; c++) begin
      #3;
      if (md_rx_ready) begin ok = 1; err = md_rx_err; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin chk("rx_accept_timeout", 0, 1); err = 0; end
    @(posedge clk); #1;
    md_rx_valid = 0;
  endtask

  initial begin
    logic [31:0] rd;
    bit e, e2;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 0);
    chk("rst_pready", pready, 0);
    chk("rst_rx_ready", md_rx_ready, 0);
    chk("rst_tx_valid", md_tx_valid, 0);
    chk("rst_tx_data", md_tx_data, 0);
    rst_n = 0;

    apb_read(16'h0000, rd, e);  chk("ctrl_reset", rd, 32'h1);  chk("ctrl_rd_err", e, 0);
    apb_read(16'h000C, rd, e);  chk("status_reset", rd, 0);
    apb_read(16'h0004, rd, e);  chk("unmapped_err", e, 1);     chk("unmapped_rd", rd, 0);

    // size 1 / offset 0: one 4-byte push splits into four single-byte transfers
    apb_write(16'h0000, 32'h1, e); chk("ctrl_wr1_err", e, 0);
    md_tx_ready = 1;
    rx_push(32'hDDCCBBAA, 2'd0, 3'd4, e);
    repeat (12) @(posedge clk);
    chk("txlog_n", txlog.size(), 4);
    if (txlog.size() >= 4) begin
      chk("tx0", txlog[0], 8'hAA); chk("tx1", txlog[1], 8'hBB);
      chk("tx2", txlog[2], 8'hCC); chk("tx3", txlog[3], 8'hDD);
    end

    // size 2 / offset 2: two single bytes gathered into lanes 2..3
    #1 md_tx_ready = 0;
    apb_write(16'h0000, 32'h0202, e); chk("ctrl_wr2_err", e, 0);
    rx_push(32'h000000AA, 2'd0, 3'd1, e);
    rx_push(32'h0000BB00, 2'd1, 3'd1, e);
    #3;
    chk("lit_tx_valid", md_tx_valid, 1);
    chk("lit_tx_data", md_tx_data, 32'hBBAA0000);
    chk("lit_tx_off", md_tx_offset, 2);
    chk("lit_tx_size", md_tx_size, 2);
    @(posedge clk); #1 md_tx_ready = 1;
    @(posedge clk); #1 md_tx_ready = 0;

    // illegal RX and counter clear
    rx_push(32'h0, 2'd3, 3'd2, e);  chk("illegal_err", e, 1);
    apb_read(16'h000C, rd, e);      chk("cnt_one", rd, 32'h1);
    apb_write(16'h0000, 32'h10202, e); chk("clr_err", e, 0);
    apb_read(16'h000C, rd, e);      chk("cnt_clr", rd, 0);
    apb_read(16'h0000, rd, e);      chk("ctrl_clr_reads0", rd, 32'h0202);
    fork
      apb_write(16'h0000, 32'h10202, e);
      begin @(posedge clk); rx_push(32'h0, 2'd3, 3'd2, e2); end
    join
    apb_read(16'h000C, rd, e);      chk("clr_and_drop", rd, 32'h1);

    // size 4: the third push stalls until a pop frees space
    apb_write(16'h0000, 32'h4, e);
    rx_push(32'h03020100, 2'd0, 3'd4, e);
    rx_push(32'h07060504, 2'd0, 3'd4, e);
    @(posedge clk); #1;
    md_rx_valid = 1; md_rx_data = 32'h0B0A0908; md_rx_offset = 0; md_rx_size = 4;
    repeat (3) begin #3 chk("stall_ready", md_rx_ready, 0); @(posedge clk); #1; end
    apb_read(16'h000C, rd, e);      chk("status_full", rd, 32'h801);
    chk("tx_full_data", md_tx_data, 32'h03020100);
    md_tx_ready = 1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (md_rx_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("stall_release", ok, 1);
    @(posedge clk); #1 md_rx_valid = 0;
    repeat (8) @(posedge clk);
    #1 md_tx_ready = 0;
    apb_read(16'h000C, rd, e);      chk("drained", rd, 32'h1);

    // rejected writes leave registers alone
    apb_write(16'h0000, 32'h0203, e); chk("bad_ctrl_err", e, 1);
    apb_read(16'h0000, rd, e);        chk("ctrl_unchanged", rd, 32'h4);
    apb_write(16'h000C, 32'h0, e);    chk("status_wr_err", e, 1);
    apb_write(16'h0000, 32'h0, e);    chk("size0_err", e, 1);

    // asynchronous reset aborts an outstanding transfer
    apb_write(16'h0000, 32'h1, e);
    rx_push(32'h0000005A, 2'd0, 3'd1, e);
    #3 chk("pre_rst_valid", md_tx_valid, 1);
    @(posedge clk); #1 rst_n = 1;
    #1;
    chk("async_rst_valid", md_tx_valid, 0);
    chk("async_rst_data", md_tx_data, 0);
    chk("async_rst_size", md_tx_size, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    apb_read(16'h0000, rd, e);      chk("post_rst_ctrl", rd, 32'h1);
    apb_read(16'h000C, rd, e);      chk("post_rst_status", rd, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
